// File: rtl/mult_sequencer.sv
// mult_sequencer
// Two-requester front end for the 32x32 combinational multiplier in the
// execute stage. Requesters are arbitrated round-robin. The winner's operands
// are converted to magnitudes and registered into the array. They are then
// held for WAIT_CYCLES settle cycles. The product is sign-corrected and
// returned with a one-cycle done pulse.
//
// Ports
//   clk_i                 system clock, rising edge
//   rst_ni                asynchronous active-low reset
//   req0_i / req1_i       level requests, held until the matching done pulse
//   sgn0_i / sgn1_i       1 = signed (two's complement) operands
//   a0_i, b0_i, a1_i, b1_i  32-bit operands per requester
//   done0_o / done1_o     one-cycle completion pulse to the owning requester
//   prod_o                registered 64-bit product, held until next completion
//   busy_o                high while an operation is in CALC or DONE
//   gnt_id_o              index of the current or most recent owner
//
// The path from mag_a_q/mag_b_q through the multiplier to prod_q is a
// WAIT_CYCLES multicycle path. mag_a_q/mag_b_q change only on grant edges.
module mult_sequencer #(
  parameter int unsigned WAIT_CYCLES = 2  // legal range 1..15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        sgn0_i,
  input  logic        sgn1_i,
  input  logic [31:0] a0_i,
  input  logic [31:0] b0_i,
  input  logic [31:0] a1_i,
  input  logic [31:0] b1_i,
  output logic        done0_o,
  output logic        done1_o,
  output logic [63:0] prod_o,
  output logic        busy_o,
  output logic        gnt_id_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [3:0] CntInit = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rr_q, rr_d;
  logic        gnt_q, gnt_d;
  logic        neg_q, neg_d;
  logic [31:0] mag_a_q, mag_a_d;
  logic [31:0] mag_b_q, mag_b_d;
  logic [63:0] prod_q, prod_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        busy_q, busy_d;

  // Arbitration winner and its operand set. Under contention the winner is
  // the rr pointer. With a single request, that requester wins.
  logic        anyReq;
  logic        winId;
  logic        selSgn;
  logic [31:0] selA, selB;
  logic [63:0] multResult;

  assign anyReq = req0_i | req1_i;
  assign winId  = (req0_i & req1_i) ? rr_q : req1_i;
  assign selSgn = winId ? sgn1_i : sgn0_i;
  assign selA   = winId ? a1_i   : a0_i;
  assign selB   = winId ? b1_i   : b0_i;

  // Unsigned array on magnitudes. -2^31 maps to 0x8000_0000, which is exact
  // as an unsigned magnitude.
  assign multResult = {32'd0, mag_a_q} * {32'd0, mag_b_q};

  // Next-state logic. The output registers are derived from the next state,
  // so done/busy stay registered while lining up with the state they describe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    neg_d   = neg_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    prod_d  = prod_q;

    unique case (state_q)
      IDLE: begin
        if (anyReq) begin
          gnt_d   = winId;
          neg_d   = selSgn & (selA[31] ^ selB[31]);
          mag_a_d = (selSgn & selA[31]) ? (~selA + 32'd1) : selA;
          mag_b_d = (selSgn & selB[31]) ? (~selB + 32'd1) : selB;
          cnt_d   = CntInit;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // The signed magnitude product is at most 2^62, so negation is exact.
          prod_d  = neg_q ? (~multResult + 64'd1) : multResult;
          rr_d    = ~gnt_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done0_d = (state_d == DONE) & ~gnt_d;
    done1_d = (state_d == DONE) &  gnt_d;
    busy_d  = (state_d != IDLE);
  end

  // State and datapath registers.
  // Reset discards any operation in flight, and no done pulse follows.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rr_q    <= 1'b0;
      gnt_q   <= 1'b0;
      neg_q   <= 1'b0;
      mag_a_q <= 32'd0;
      mag_b_q <= 32'd0;
      prod_q  <= 64'd0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      neg_q   <= neg_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      prod_q  <= prod_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
    end
  end

  assign done0_o  = done0_q;
  assign done1_o  = done1_q;
  assign prod_o   = prod_q;
  assign busy_o   = busy_q;
  assign gnt_id_o = gnt_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer
// Directed and random bench for mult_sequencer. Each issued operation pushes
// its expected owner and product onto a scoreboard queue. The entry is popped
// and compared when a done pulse appears. Inputs are driven on the falling
// edge, and outputs are sampled there.
module tb_mult_sequencer;

  localparam int unsigned WC = 2;

  typedef struct {
    bit          id;
    logic [63:0] p;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        req0, req1, sgn0, sgn1;
  logic [31:0] a0, b0, a1, b1;
  logic        done0, done1, busy, gntId;
  logic [63:0] prod;

  exp_t sbQ[$];
  int   compared = 0;
  int   mismatched = 0;

  mult_sequencer #(.WAIT_CYCLES(WC)) dut (
    .clk_i   (clk),
    .rst_ni  (rstN),
    .req0_i  (req0),
    .req1_i  (req1),
    .sgn0_i  (sgn0),
    .sgn1_i  (sgn1),
    .a0_i    (a0),
    .b0_i    (b0),
    .a1_i    (a1),
    .b1_i    (b1),
    .done0_o (done0),
    .done1_o (done1),
    .prod_o  (prod),
    .busy_o  (busy),
    .gnt_id_o(gntId)
  );

  always #5 clk = ~clk;

  // Reference product: sign-extend to 64 bits and multiply modulo 2^64.
  function automatic logic [63:0] refProd(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Raise the request for one requester and record the expected result.
  task automatic applyStimulus(input bit id, input bit s, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] p);
    if (id == 1'b0) begin
      req0 = 1'b1; sgn0 = s; a0 = a; b0 = b;
    end else begin
      req1 = 1'b1; sgn1 = s; a1 = a; b1 = b;
    end
    sbQ.push_back('{id, p});
  endtask

  // Wait (bounded) for the next done pulse and check it against the
  // scoreboard head. Unless keep is set, the owner then drops its request.
  task automatic serve(input bit keep, input int expLat);
    int   lat;
    bit   got;
    exp_t e;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < int'(WC) + 12 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (done0 | done1) got = 1'b1;
    end
    checkOutput("done_seen", 64'(got), 64'd1);
    checkOutput("sb_nonempty", 64'(sbQ.size() != 0), 64'd1);
    if (!got || sbQ.size() == 0) return;
    e = sbQ.pop_front();
    checkOutput("done0", 64'(done0), 64'(!e.id));
    checkOutput("done1", 64'(done1), 64'(e.id));
    checkOutput("gnt_id", 64'(gntId), 64'(e.id));
    checkOutput("prod", prod, e.p);
    checkOutput("busy_in_done", 64'(busy), 64'd1);
    if (expLat > 0) checkOutput("latency", 64'(lat), 64'(expLat));
    if (!keep) begin
      if (e.id == 1'b0) req0 = 1'b0;
      else              req1 = 1'b0;
    end
  endtask

  initial begin
    int          seen;
    bit          s;
    bit          id;
    logic [31:0] ra, rb;

    rstN = 1'b0;
    req0 = 1'b0; req1 = 1'b0; sgn0 = 1'b0; sgn1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_prod", prod, 64'd0);
    checkOutput("rst_done", {62'd0, done1, done0}, 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_gnt", 64'(gntId), 64'd0);
    rstN = 1'b1;

    // Unsigned max x max on requester 0.
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    serve(1'b0, WC + 1);
    @(negedge clk);
    checkOutput("done_one_cycle", 64'(done0), 64'd0);
    checkOutput("busy_after_done", 64'(busy), 64'd0);
    checkOutput("prod_held", prod, 64'hFFFF_FFFE_0000_0001);

    // Signed corners, alternating requesters.
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    serve(1'b0, WC + 1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    serve(1'b0, WC + 1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
    serve(1'b0, WC + 1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd0, 64'd0);
    serve(1'b0, WC + 1);

    // Operand change during CALC, with req1 arriving mid-operation.
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'd1000, 32'd3000, 64'd3000000);
    @(negedge clk);
    checkOutput("busy_in_calc", 64'(busy), 64'd1);
    a0 = 32'h1234_5678;
    sgn0 = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFE, 32'd5, 64'hFFFF_FFFF_FFFF_FFF6);
    serve(1'b0, WC);
    serve(1'b0, WC + 2);

    // Requester 0 completes last, so the pointer favours requester 1 before reset.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    serve(1'b0, WC + 1);

    // Reset asserted mid-operation.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'd9, 32'd9, 64'd81);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("midrst_prod", prod, 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_gnt", 64'(gntId), 64'd0);
    checkOutput("midrst_done", {62'd0, done1, done0}, 64'd0);
    sbQ.delete();
    req1 = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    seen = 0;
    repeat (3 * WC + 10) begin
      @(negedge clk);
      if (done0 | done1) seen++;
    end
    checkOutput("no_spurious_done", 64'(seen), 64'd0);

    // Contention from reset: both held high, so grants alternate 0,1,0,1.
    applyStimulus(1'b0, 1'b0, 32'd11, 32'd13, 64'd143);
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
    serve(1'b1, WC + 1);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF0, 32'd16, 64'hFFFF_FFFF_FFFF_FF00);
    serve(1'b1, WC + 2);
    applyStimulus(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    serve(1'b0, WC + 2);
    serve(1'b0, WC + 2);

    // Random operands against the reference model.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      s  = 1'($urandom_range(0, 1));
      id = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
      applyStimulus(id, s, ra, rb, refProd(s, ra, rb));
      serve(1'b0, WC + 1);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Two-requester controller for the 32x32 combinational multiplier. It arbitrates between requesters round-robin and registers the winner's operands into the multiplier. Because the multiplier array is far longer than one clock period, it holds those operands stable for a programmable number of settle cycles. It then adds signed-multiply support by magnitude conversion and sign correction, and returns a registered 64-bit product with a one-cycle completion pulse. It sits beside the ALU in the KGP-RISC execute stage; the ALU multiply path is requester 0 and the multi-cycle/debug path is requester 1.

## Interface
- WAIT_CYCLES, 2: settle cycles granted to the combinational array, legal range 1..15.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0, req1  in  1 each  level request; requester holds it, and its operands, until it samples its done pulse.
- sgn0, sgn1  in  1 each  1 = signed (two's complement) operands, 0 = unsigned.
- a0, b0, a1, b1  in  32 each  operands.
- done0, done1  out  1 each  one-cycle completion pulse to the owning requester.
- prod  out  64  registered product; valid in the done cycle and held until the next completion.
- busy  out  1  high while an operation is in flight (CALC or DONE).
- gnt_id  out  1  index of the current or most recent owner.

## Operation
- Internal multiplier instance is fed from registered magnitudes mag_a, mag_b, each 32 bits.
- State IDLE:
  - If no request, remain in IDLE.
  - If one request is high, grant it.
  - If both are high, grant the requester indicated by priority pointer rr.
  - On the grant edge:
    - latch gnt_id;
    - latch neg = sgn & (a[31] ^ b[31]);
    - latch mag_a = (sgn & a[31]) ? -a : a, and likewise mag_b;
    - load cnt = WAIT_CYCLES - 1;
    - go to CALC.
  - -2^31 becomes magnitude 0x8000_0000, which is correct as unsigned.
- State CALC:
  - If cnt != 0, decrement cnt.
  - If cnt == 0:
    - register prod = neg ? -(mult_result) : mult_result, as 64-bit two's complement;
    - set rr = ~gnt_id;
    - go to DONE.
- State DONE:
  - Assert done[gnt_id] for exactly one cycle.
  - Next state is IDLE unconditionally.
- Requester protocol: a requester deasserts req, or presents a new operation, on the edge where it samples done high. The sequencer does not sample req in DONE, so there is no double grant.
- Requests arriving in CALC or DONE wait; they are arbitrated on the next IDLE cycle.
- Operand or sgn changes after the grant edge are ignored.
- Unsigned overflow is impossible: max product is (2^32-1)^2 < 2^64. Signed magnitude product is at most 2^62, so negation is exact.

## Timing
- Reset (rst low, asynchronous): state = IDLE, prod = 0, done0 = done1 = 0, busy = 0, gnt_id = 0, rr = 0 (requester 0 has priority), cnt = 0, mag_a = mag_b = 0.
- Reset asserted mid-operation discards the operation; no done pulse is issued.
- Latency: req sampled high in IDLE at edge E → CALC for WAIT_CYCLES cycles → done high in the cycle following edge E + WAIT_CYCLES. With WAIT_CYCLES = 2, done appears 3 cycles after the request is sampled.
- Back-to-back operations: IDLE occupies one cycle between operations, so throughput is one product per WAIT_CYCLES + 2 cycles.
- busy rises the cycle after the grant edge and falls the cycle after DONE.
- prod, done and busy are all registered; there are no combinational paths from req or operands to outputs.
- Multiplier inputs change only on grant edges. The multiplier-to-prod path is a WAIT_CYCLES multicycle path and must be constrained accordingly.

## Test plan
- Unsigned single operation: req0, sgn0 = 0, a0 = 0xFFFF_FFFF, b0 = 0xFFFF_FFFF, WAIT_CYCLES = 2 → done0 pulses 3 cycles later with prod = 0xFFFF_FFFE_0000_0001; done1 stays 0.
- Signed corners (sgn = 1):
  - -1 × 1 → 0xFFFF_FFFF_FFFF_FFFF;
  - 0x8000_0000 × 0x8000_0000 → 0x4000_0000_0000_0000;
  - 0x8000_0000 × 1 → 0xFFFF_FFFF_8000_0000;
  - -7 × 0 → 0.
- Contention: req0 and req1 rise in the same cycle from reset.
  - Requester 0 is served first, then requester 1 on the next IDLE.
  - Both held high continuously → grants alternate 0, 1, 0, 1; gnt_id tracks each grant.
- Operand stability: change a0 during CALC → prod reflects the operands latched at grant. A req1 raised during CALC is granted in the IDLE cycle after done0.
- Reset mid-op: drop rst during CALC → all outputs 0 immediately. After release with no request, no done pulse ever appears. A fresh request then completes normally.
- WAIT_CYCLES = 1 and 15 builds: done latency is 2 and 16 cycles respectively; products match the reference model over 10k random signed/unsigned operand pairs.
